// File: rtl/episode_ctrl.sv
// Episode sequencer for the 8x8 gridworld: loads the start cell, walks one saturating step per accepted
// action, and keeps a running "never red" verdict that is reported once the episode ends.
module episode_ctrl #(
  parameter int HORIZON    = 48,
  parameter int X0         = 3,
  parameter int Y0         = 0,
  parameter int EARLY_STOP = 0,
  parameter int CW         = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          act_valid,
  input  logic [2:0]    act,
  output logic          act_ready,
  output logic [2:0]    pos_x,
  output logic [2:0]    pos_y,
  output logic [3:0]    colour,
  output logic [CW-1:0] step_cnt,
  output logic          busy,
  output logic          done,
  output logic          pass
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0]    X0_L    = 3'(X0);
  localparam logic [2:0]    Y0_L    = 3'(Y0);
  localparam logic [CW-1:0] HOR_L   = CW'(HORIZON);
  localparam bit            ES      = (EARLY_STOP != 0);

  function automatic logic is_red(input logic [2:0] x, input logic [2:0] y);
    logic inner_col, edge_col, inner_row, edge_row;
    inner_col = (x == 3'd1) || (x == 3'd6);
    edge_col  = (x == 3'd0) || (x == 3'd7);
    edge_row  = (y == 3'd1) || (y == 3'd4) || (y == 3'd5);
    inner_row = edge_row || (y == 3'd0);
    is_red    = (inner_col && inner_row) || (edge_col && edge_row);
  endfunction

  function automatic logic [3:0] decode_colour(input logic [2:0] x, input logic [2:0] y);
    logic blue, yellow, brown;
    logic y_edge;
    y_edge        = (y == 3'd0) || (y == 3'd7);
    blue          = (x >= 3'd3) && (x <= 3'd4) && (y >= 3'd2) && (y <= 3'd5);
    yellow        = ((x == 3'd0) || (x == 3'd7)) && y_edge;
    brown         = (x >= 3'd2) && (x <= 3'd5) && y_edge;
    decode_colour = {blue, yellow, brown, is_red(x, y)};
  endfunction

  function automatic logic signed [1:0] x_delta(input logic [2:0] a);
    case (a)
      3'd1, 3'd2, 3'd3: x_delta = 2'sd1;
      3'd5, 3'd6, 3'd7: x_delta = -2'sd1;
      default:          x_delta = 2'sd0;
    endcase
  endfunction

  function automatic logic signed [1:0] y_delta(input logic [2:0] a);
    case (a)
      3'd7, 3'd0, 3'd1: y_delta = 2'sd1;
      3'd3, 3'd4, 3'd5: y_delta = -2'sd1;
      default:          y_delta = 2'sd0;
    endcase
  endfunction

  // Clamp to the grid instead of wrapping.
  function automatic logic [2:0] sat_step(input logic [2:0] p, input logic signed [1:0] d);
    logic signed [4:0] sum;
    sum = $signed({2'b00, p}) + $signed({{3{d[1]}}, d});
    if (sum < 5'sd0)      sat_step = 3'd0;
    else if (sum > 5'sd7) sat_step = 3'd7;
    else                  sat_step = sum[2:0];
  endfunction

  state_t        state, state_nx;
  logic          red_seen;
  logic          load;
  logic          accept;
  logic          last;
  logic          red_new;
  logic          start_red;
  logic [2:0]    nx_x, nx_y;
  logic [CW-1:0] cnt_inc;

  assign accept    = (state == S_RUN) && act_valid;
  assign nx_x      = sat_step(pos_x, x_delta(act));
  assign nx_y      = sat_step(pos_y, y_delta(act));
  assign red_new   = is_red(nx_x, nx_y);
  assign start_red = is_red(X0_L, Y0_L);
  assign cnt_inc   = step_cnt + 1'b1;
  assign last      = (cnt_inc == HOR_L);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = (ES && start_red) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept && (last || (ES && red_new))) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Position, count and verdict update on the edge that loads or accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x    <= X0_L;
      pos_y    <= Y0_L;
      step_cnt <= '0;
      red_seen <= 1'b0;
    end else if (load) begin
      pos_x    <= X0_L;
      pos_y    <= Y0_L;
      step_cnt <= '0;
      red_seen <= start_red;
    end else if (accept) begin
      pos_x    <= nx_x;
      pos_y    <= nx_y;
      step_cnt <= cnt_inc;
      red_seen <= red_seen | red_new;
    end
  end

  assign colour    = decode_colour(pos_x, pos_y);
  assign busy      = (state == S_RUN);
  assign act_ready = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign pass      = done && !red_seen;

endmodule
